system_cpu_mul_seq: RTL



---
 rtl/system_cpu_mul_seq.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/system_cpu_mul_seq.sv
// Multiply sequencer in front of system_cpu_mult_cell: MUL returns the low word, MULX* builds the high word
// from four 16x16 partial products. Define SYSTEM_CPU_MUL_SIGNED_EN to build the signed high-word correction.
module system_cpu_mul_seq #(
  parameter int CELL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] A_mul_src1,
  output logic [31:0] A_mul_src2,
  input  logic [31:0] A_mul_cell_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy
);

  localparam logic [1:0] OP_MUL = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CORR  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [31:0]           a_r;
  logic [31:0]           b_r;
  logic [1:0]            op_r;
  logic [1:0]            issue_cnt_r;
  logic [1:0]            issue_cnt_s;
  logic [31:0]           src1_r;
  logic [31:0]           src2_r;
  logic [31:0]           src1_s;
  logic [31:0]           src2_s;
  logic [CELL_LATENCY:0] tag_vld_r;
  logic [1:0]            tag_idx_r [CELL_LATENCY+1];
  logic [63:0]           acc_r;
  logic [31:0]           rsp_data_r;
  logic [31:0]           rsp_data_s;
  logic [31:0]           corr_s;
  logic                  issue_s;
  logic                  is_mul_s;
  logic                  accept_s;
  logic                  ret_s;
  logic                  ret_last_s;
  logic [1:0]            last_idx_s;

  // Place a returned 32-bit partial product at its weight inside the 64-bit sum.
  function automatic logic [63:0] shifted_partial(input logic [1:0] idx, input logic [31:0] prod);
    case (idx)
      2'd0:    shifted_partial = {32'h0, prod};
      2'd1:    shifted_partial = {16'h0, prod, 16'h0};
      2'd2:    shifted_partial = {16'h0, prod, 16'h0};
      2'd3:    shifted_partial = {prod, 32'h0};
      default: shifted_partial = 64'h0;
    endcase
  endfunction

  function automatic logic [31:0] half_sel(input logic [31:0] v, input logic upper);
    half_sel = upper ? {16'h0, v[31:16]} : {16'h0, v[15:0]};
  endfunction

  assign is_mul_s   = (op_r == OP_MUL);
  assign last_idx_s = is_mul_s ? 2'd0 : 2'd3;
  assign req_ready  = (state_r == ST_IDLE) & ~reset;
  assign accept_s   = req_valid & req_ready;
  assign ret_s      = tag_vld_r[CELL_LATENCY];
  assign ret_last_s = ret_s & (tag_idx_r[CELL_LATENCY] == last_idx_s);

`ifdef SYSTEM_CPU_MUL_SIGNED_EN
  localparam logic [1:0] OP_XUU = 2'b01;
  localparam logic [1:0] OP_XSS = 2'b10;
  localparam logic [1:0] OP_XSU = 2'b11;

  // Signed high word = unsigned high word minus the sign-weighted opposite operand(s).
  always_comb begin
    corr_s = 32'h0;
    case (op_r)
      OP_XSS:  corr_s = (a_r[31] ? b_r : 32'h0) + (b_r[31] ? a_r : 32'h0);
      OP_XSU:  corr_s = a_r[31] ? b_r : 32'h0;
      OP_XUU:  corr_s = 32'h0;
      default: corr_s = 32'h0;
    endcase
  end
`else
  assign corr_s = 32'h0;
`endif

  // Next-state, operand selection and response word.
  always_comb begin
    state_s     = state_r;
    issue_cnt_s = issue_cnt_r;
    issue_s     = 1'b0;
    src1_s      = 32'h0;
    src2_s      = 32'h0;
    rsp_data_s  = rsp_data_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          state_s     = ST_ISSUE;
          issue_cnt_s = 2'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        issue_s = 1'b1;
        if (is_mul_s) begin
          src1_s  = a_r;
          src2_s  = b_r;
          state_s = ST_DRAIN;
        end else begin
          // Order lo*lo, hi*lo, lo*hi, hi*hi: bit0 picks the a half, bit1 the b half.
          src1_s      = half_sel(a_r, issue_cnt_r[0]);
          src2_s      = half_sel(b_r, issue_cnt_r[1]);
          issue_cnt_s = issue_cnt_r + 2'd1;
          if (issue_cnt_r == 2'd3) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_ISSUE;
          end
        end
      end
      ST_DRAIN: begin
        if (ret_last_s) begin
          if (is_mul_s) begin
            rsp_data_s = A_mul_cell_result;
            state_s    = ST_RESP;
          end else begin
            state_s = ST_CORR;
          end
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_CORR: begin
        rsp_data_s = acc_r[63:32] - corr_s;
        state_s    = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Control state, captured request and registered cell operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      issue_cnt_r <= 2'd0;
      a_r         <= 32'h0;
      b_r         <= 32'h0;
      op_r        <= 2'b00;
      src1_r      <= 32'h0;
      src2_r      <= 32'h0;
      rsp_data_r  <= 32'h0;
    end else begin
      state_r     <= state_s;
      issue_cnt_r <= issue_cnt_s;
      src1_r      <= src1_s;
      src2_r      <= src2_s;
      rsp_data_r  <= rsp_data_s;
      if (accept_s) begin
        a_r  <= req_a;
        b_r  <= req_b;
        op_r <= req_op;
      end
    end
  end

  // Tag each issued product so its return lines up CELL_LATENCY cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld_r <= '0;
      for (int i = 0; i <= CELL_LATENCY; i++) begin
        tag_idx_r[i] <= 2'd0;
      end
    end else begin
      tag_vld_r    <= {tag_vld_r[CELL_LATENCY-1:0], issue_s};
      tag_idx_r[0] <= issue_cnt_r;
      for (int i = 1; i <= CELL_LATENCY; i++) begin
        tag_idx_r[i] <= tag_idx_r[i-1];
      end
    end
  end

  // 64-bit partial-product accumulator, cleared when a request is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r <= 64'h0;
    end else if (accept_s) begin
      acc_r <= 64'h0;
    end else if (ret_s && !is_mul_s) begin
      acc_r <= acc_r + shifted_partial(tag_idx_r[CELL_LATENCY], A_mul_cell_result);
    end
  end

  assign A_mul_src1 = src1_r;
  assign A_mul_src2 = src2_r;
  assign rsp_valid  = (state_r == ST_RESP);
  assign rsp_data   = rsp_data_r;
  assign busy       = (state_r != ST_IDLE);

endmodule
